// File: rtl/duty_ramp_ctrl_if.sv
// Command/status bundle between the steering logic (master) and duty_ramp_ctrl (slave).
// Signal names match the block's port list; the optional ramp_done stays a plain port.
interface duty_ramp_ctrl_if;
  logic       period_tick;
  logic       cmd_vld;
  logic       cmd_rdy;
  logic [9:0] cmd_duty;
  logic       cmd_dir;
  logic       brake;
  logic [9:0] duty;
  logic       dir;
  logic       busy;

  modport master (
    output period_tick, cmd_vld, cmd_duty, cmd_dir, brake,
    input  cmd_rdy, duty, dir, busy
  );

  modport slave (
    input  period_tick, cmd_vld, cmd_duty, cmd_dir, brake,
    output cmd_rdy, duty, dir, busy
  );
endinterface

// File: rtl/duty_ramp_ctrl.sv
// Slew-limited duty/direction feeder for the PWM generator, with reversal dead time and brake.
// Optional macro DUTY_RAMP_DONE_EN adds the ramp_done pulse output.
//
// state | meaning
// IDLE  | duty/dir equal the accepted target
// RAMP  | stepping duty toward target (toward 0 first when a reversal is pending)
// DEAD  | duty held at 0 for DEAD_PERIODS ticks before dir may change
// BRAKE | duty forced to 0, commands refused
module duty_ramp_ctrl #(
  parameter int STEP         = 16,
  parameter int DUTY_MAX     = 1000,
  parameter int DEAD_PERIODS = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  duty_ramp_ctrl_if.slave bus
`ifdef DUTY_RAMP_DONE_EN
  ,
  output logic            ramp_done
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RAMP  = 2'd1,
    DEAD  = 2'd2,
    BRAKE = 2'd3
  } state_t;

  localparam logic [10:0] STEP_W   = 11'(STEP);
  localparam logic [9:0]  DUTY_CAP = 10'(DUTY_MAX);
  localparam logic [3:0]  DEAD_CNT = 4'(DEAD_PERIODS);

  state_t     state_q, state_d;
  logic [9:0] duty_q, duty_d;
  logic       dir_q, dir_d;
  logic [9:0] tgt_duty_q, tgt_duty_d;
  logic       tgt_dir_q, tgt_dir_d;
  logic [3:0] cnt_q, cnt_d;

  logic       accept;
  logic [9:0] cmd_clamped;
  logic [9:0] eff;
  logic [9:0] ramp_duty;
  logic [10:0] eff_w, duty_w, diff_w;
  logic        step_up;

  assign bus.cmd_rdy = (state_q != BRAKE);
  assign bus.duty    = duty_q;
  assign bus.dir     = dir_q;
  assign bus.busy    = (duty_q != tgt_duty_q) || (dir_q != tgt_dir_q) || (state_q != IDLE);

  assign accept      = bus.cmd_vld && bus.cmd_rdy;
  assign cmd_clamped = (bus.cmd_duty > DUTY_CAP) ? DUTY_CAP : bus.cmd_duty;

  // A pending reversal ramps to zero first.
  assign eff    = (tgt_dir_q != dir_q) ? 10'd0 : tgt_duty_q;
  assign eff_w  = {1'b0, eff};
  assign duty_w = {1'b0, duty_q};

  always_comb begin
    step_up   = 1'b0;
    diff_w    = '0;
    ramp_duty = duty_q;
    if (eff_w >= duty_w) begin
      step_up = 1'b1;
      diff_w  = eff_w - duty_w;
    end else begin
      diff_w  = duty_w - eff_w;
    end
    if (diff_w <= STEP_W) begin
      ramp_duty = eff;
    end else if (step_up) begin
      ramp_duty = 10'(duty_w + STEP_W);
    end else begin
      ramp_duty = 10'(duty_w - STEP_W);
    end
  end

  always_comb begin
    state_d    = state_q;
    duty_d     = duty_q;
    dir_d      = dir_q;
    tgt_duty_d = tgt_duty_q;
    tgt_dir_d  = tgt_dir_q;
    cnt_d      = cnt_q;

    if (bus.brake) begin
      state_d    = BRAKE;
      duty_d     = 10'd0;
      tgt_duty_d = 10'd0;
      tgt_dir_d  = dir_q;
    end else begin
      if (accept) begin
        tgt_duty_d = cmd_clamped;
        tgt_dir_d  = bus.cmd_dir;
      end

      // Stepping uses the registered (pre-accept) target.
      unique case (state_q)
        IDLE: ;
        RAMP: begin
          if (bus.period_tick) begin
            duty_d = ramp_duty;
            if (ramp_duty == eff) begin
              if (dir_q != tgt_dir_q) begin
                state_d = DEAD;
                cnt_d   = DEAD_CNT;
              end else begin
                state_d = IDLE;
              end
            end
          end
        end
        DEAD: begin
          duty_d = 10'd0;
          if (bus.period_tick) begin
            if (cnt_q <= 4'd1) begin
              cnt_d   = 4'd0;
              dir_d   = tgt_dir_q;
              state_d = IDLE;
            end else begin
              cnt_d = cnt_q - 4'd1;
            end
          end
        end
        BRAKE: begin
          duty_d  = 10'd0;
          state_d = DEAD;
          cnt_d   = DEAD_CNT;
        end
        default: state_d = IDLE;
      endcase

      // IDLE only holds while output equals the (possibly just updated) target.
      if ((state_d == IDLE) && ((duty_d != tgt_duty_d) || (dir_d != tgt_dir_d))) begin
        state_d = RAMP;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      duty_q     <= '0;
      dir_q      <= 1'b0;
      tgt_duty_q <= '0;
      tgt_dir_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      duty_q     <= duty_d;
      dir_q      <= dir_d;
      tgt_duty_q <= tgt_duty_d;
      tgt_dir_q  <= tgt_dir_d;
      cnt_q      <= cnt_d;
    end
  end

`ifdef DUTY_RAMP_DONE_EN
  logic ramp_done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ramp_done_q <= 1'b0;
    end else begin
      ramp_done_q <= (state_d == IDLE) && ((state_q == RAMP) || (state_q == DEAD));
    end
  end

  assign ramp_done = ramp_done_q;
`endif

endmodule

// File: tb/tb_duty_ramp_ctrl.sv
// Directed bench for duty_ramp_ctrl: ramp, clamp, reversal dead time, brake, same-cycle
// accept/tick and async reset, all against hand-computed values.
module tb_duty_ramp_ctrl;
  localparam int GAP = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   rd_cnt = 0;

  duty_ramp_ctrl_if bus_if ();

`ifdef DUTY_RAMP_DONE_EN
  logic ramp_done;
`endif

  duty_ramp_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
`ifdef DUTY_RAMP_DONE_EN
    ,
    .ramp_done (ramp_done)
`endif
  );

  always #5 clk = ~clk;

`ifdef DUTY_RAMP_DONE_EN
  always @(posedge clk) if (ramp_done) rd_cnt <= rd_cnt + 1;
`endif

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick();
    bus_if.period_tick = 1'b1;
    cyc(1);
    bus_if.period_tick = 1'b0;
    cyc(GAP - 1);
  endtask

  task automatic send(input int d, input bit r);
    bus_if.cmd_vld  = 1'b1;
    bus_if.cmd_duty = 10'(d);
    bus_if.cmd_dir  = r;
    cyc(1);
    bus_if.cmd_vld  = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
  endtask

  initial begin
    bus_if.period_tick = 1'b0;
    bus_if.cmd_vld     = 1'b0;
    bus_if.cmd_duty    = '0;
    bus_if.cmd_dir     = 1'b0;
    bus_if.brake       = 1'b0;
    cyc(2);
    check("rst_duty", bus_if.duty, 0);
    check("rst_dir", bus_if.dir, 0);
    check("rst_rdy", bus_if.cmd_rdy, 1);
    check("rst_busy", bus_if.busy, 0);
    rst_n = 1'b1;
    cyc(1);

    // Basic ramp to 100
    send(100, 0);
    check("t1_busy_start", bus_if.busy, 1);
    for (int i = 1; i <= 7; i++) begin
      tick();
      check("t1_duty", bus_if.duty, (i < 7) ? 16 * i : 100);
    end
    check("t1_busy_end", bus_if.busy, 0);

    // Clamp: 100 -> 500 in 25 ticks, then 1023 clamps to 1000
    send(500, 0);
    repeat (25) tick();
    check("t2_duty500", bus_if.duty, 500);
    check("t2_busy500", bus_if.busy, 0);
    send(1023, 0);
    for (int i = 1; i <= 32; i++) begin
      tick();
      check("t2_duty", bus_if.duty, (500 + 16 * i > 1000) ? 1000 : 500 + 16 * i);
    end
    tick();
    check("t2_hold1000", bus_if.duty, 1000);
    check("t2_busy_end", bus_if.busy, 0);

    // Reversal with dead time
    do_reset();
    send(40, 0);
    repeat (3) tick();
    check("t3_duty40", bus_if.duty, 40);
    send(40, 1);
    tick(); check("t3_down1", bus_if.duty, 24);
    tick(); check("t3_down2", bus_if.duty, 8);
    tick(); check("t3_down3", bus_if.duty, 0);
    check("t3_dir_hold", bus_if.dir, 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("t3_dead_duty", bus_if.duty, 0);
      check("t3_dead_dir", bus_if.dir, 0);
    end
    tick();
    check("t3_dir_flip", bus_if.dir, 1);
    check("t3_flip_duty", bus_if.duty, 0);
    tick(); check("t3_up1", bus_if.duty, 16);
    tick(); check("t3_up2", bus_if.duty, 32);
    tick(); check("t3_up3", bus_if.duty, 40);
    check("t3_busy_end", bus_if.busy, 0);
    check("t3_dir_end", bus_if.dir, 1);

    // Brake while ramping
    do_reset();
    send(600, 0);
    repeat (19) tick();
    check("t4_duty304", bus_if.duty, 304);
    bus_if.brake = 1'b1;
    cyc(1);
    check("t4_brk_duty", bus_if.duty, 0);
    check("t4_brk_rdy", bus_if.cmd_rdy, 0);
    check("t4_brk_busy", bus_if.busy, 1);
    bus_if.cmd_vld     = 1'b1;
    bus_if.cmd_duty    = 10'd200;
    bus_if.cmd_dir     = 1'b1;
    bus_if.period_tick = 1'b1;
    cyc(1);
    bus_if.period_tick = 1'b0;
    cyc(8);
    check("t4_brk_duty_hold", bus_if.duty, 0);
    bus_if.brake   = 1'b0;
    bus_if.cmd_vld = 1'b0;
    cyc(1);
    check("t4_rel_rdy", bus_if.cmd_rdy, 1);
    check("t4_rel_busy", bus_if.busy, 1);
    repeat (3) tick();
    check("t4_dead_busy", bus_if.busy, 1);
    check("t4_dead_duty", bus_if.duty, 0);
    tick();
    check("t4_idle_busy", bus_if.busy, 0);
    check("t4_idle_duty", bus_if.duty, 0);
    check("t4_idle_dir", bus_if.dir, 0);
    repeat (2) tick();
    check("t4_ignored_duty", bus_if.duty, 0);
    check("t4_ignored_dir", bus_if.dir, 0);

    // Accept and tick in the same cycle
    bus_if.cmd_vld     = 1'b1;
    bus_if.cmd_duty    = 10'd50;
    bus_if.cmd_dir     = 1'b0;
    bus_if.period_tick = 1'b1;
    cyc(1);
    bus_if.cmd_vld     = 1'b0;
    bus_if.period_tick = 1'b0;
    check("t5_same_tick", bus_if.duty, 0);
    check("t5_busy", bus_if.busy, 1);
    cyc(GAP - 1);
    tick(); check("t5_next", bus_if.duty, 16);
    repeat (3) tick();
    check("t5_end", bus_if.duty, 50);
    check("t5_busy_end", bus_if.busy, 0);

    // Asynchronous reset mid-ramp
    do_reset();
    send(400, 0);
    repeat (13) tick();
    check("t6_duty208", bus_if.duty, 208);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_duty", bus_if.duty, 0);
    check("t6_async_dir", bus_if.dir, 0);
    check("t6_async_busy", bus_if.busy, 0);
    check("t6_async_rdy", bus_if.cmd_rdy, 1);
`ifdef DUTY_RAMP_DONE_EN
    check("t6_async_done", ramp_done, 0);
`endif
    cyc(2);
    rst_n = 1'b1;
    cyc(3);
`ifdef DUTY_RAMP_DONE_EN
    check("ramp_done_count", rd_cnt, 7);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
